// File: rtl/vga_timing.sv
// Raster timing generator: pixel/line counters with sync and blanking decode,
// plus a one-cycle frame tick and a running frame counter.
module vga_timing #(
  parameter int unsigned H_ACTIVE  = 1024,
  parameter int unsigned H_FP      = 24,
  parameter int unsigned H_SYNC    = 136,
  parameter int unsigned H_BP      = 160,
  parameter int unsigned V_ACTIVE  = 768,
  parameter int unsigned V_FP      = 3,
  parameter int unsigned V_SYNC    = 6,
  parameter int unsigned V_BP      = 29,
  parameter bit          HSYNC_POL = 1'b0,
  parameter bit          VSYNC_POL = 1'b0
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        ce,
  output logic [10:0] hcount_out,
  output logic        hsync_out,
  output logic        hblnk_out,
  output logic [10:0] vcount_out,
  output logic        vsync_out,
  output logic        vblnk_out,
  output logic        frame_tick,
  output logic [15:0] frame_cnt
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST       = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST       = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_BLNK_START = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYNC_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_BLNK_START = 11'(V_ACTIVE);
  localparam logic [10:0] V_SYNC_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYNC_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_bad_total
    $error("vga_timing: H_TOTAL and V_TOTAL must not exceed 2048");
  end

  logic [10:0] h_next;
  logic [10:0] v_next;
  logic        frame_wrap;

  always_comb begin
    h_next     = hcount_out;
    v_next     = vcount_out;
    frame_wrap = 1'b0;
    if (ce) begin
      if (hcount_out == H_LAST) begin
        h_next = '0;
        if (vcount_out == V_LAST) begin
          v_next     = '0;
          frame_wrap = 1'b1;
        end else begin
          v_next = vcount_out + 11'd1;
        end
      end else begin
        h_next = hcount_out + 11'd1;
      end
    end
  end

  // Flags decode the next-state counts so they land on the same cycle as the counts.
  always_ff @(posedge pclk) begin
    if (rst) begin
      hcount_out <= '0;
      vcount_out <= '0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      hsync_out  <= ~HSYNC_POL;
      vsync_out  <= ~VSYNC_POL;
      frame_tick <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      hcount_out <= h_next;
      vcount_out <= v_next;
      hblnk_out  <= (h_next >= H_BLNK_START);
      vblnk_out  <= (v_next >= V_BLNK_START);
      hsync_out  <= ((h_next >= H_SYNC_START) && (h_next < H_SYNC_END)) ? HSYNC_POL : ~HSYNC_POL;
      vsync_out  <= ((v_next >= V_SYNC_START) && (v_next < V_SYNC_END)) ? VSYNC_POL : ~VSYNC_POL;
      frame_tick <= frame_wrap;
      if (frame_wrap) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: full-size instance for line timing, reduced instance
// (8x5 raster, positive syncs) for frame-level behaviour.
module tb_vga_timing;

  logic pclk = 1'b0;
  always #5 pclk = ~pclk;

  int total = 0;
  int bad   = 0;

  // Full-size, active-low syncs
  logic        rst_f = 1'b1, ce_f = 1'b0;
  logic [10:0] hc_f, vc_f;
  logic        hs_f, hb_f, vs_f, vb_f, tk_f;
  logic [15:0] fc_f;

  vga_timing dut_full (
    .pclk(pclk), .rst(rst_f), .ce(ce_f),
    .hcount_out(hc_f), .hsync_out(hs_f), .hblnk_out(hb_f),
    .vcount_out(vc_f), .vsync_out(vs_f), .vblnk_out(vb_f),
    .frame_tick(tk_f), .frame_cnt(fc_f)
  );

  // Reduced raster: H 4+1+2+1 = 8, V 2+1+1+1 = 5, active-high syncs
  logic        rst_s = 1'b1, ce_s = 1'b0;
  logic [10:0] hc_s, vc_s;
  logic        hs_s, hb_s, vs_s, vb_s, tk_s;
  logic [15:0] fc_s;

  vga_timing #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
  ) dut_small (
    .pclk(pclk), .rst(rst_s), .ce(ce_s),
    .hcount_out(hc_s), .hsync_out(hs_s), .hblnk_out(hb_s),
    .vcount_out(vc_s), .vsync_out(vs_s), .vblnk_out(vb_s),
    .frame_tick(tk_s), .frame_cnt(fc_s)
  );

  typedef struct {
    bit r; bit c; int n;
    int h; int v; bit hs; bit hb; bit vs; bit vb; bit tk; int cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step_s(input bit r, input bit c);
    rst_s = r; ce_s = c;
    @(posedge pclk); #1;
  endtask

  task automatic step_f(input bit r, input bit c);
    rst_f = r; ce_f = c;
    @(posedge pclk); #1;
  endtask

  initial begin
    int hs_low;
    int n;
    bit phase;
    bit got;

    //              r c  n  h v hs hb vs vb tk cnt
    vecs.push_back('{1,1, 1, 0,0, 0,0, 0,0, 0,0});
    vecs.push_back('{0,1, 4, 4,0, 0,1, 0,0, 0,0});
    vecs.push_back('{0,1, 1, 5,0, 1,1, 0,0, 0,0});
    vecs.push_back('{0,1, 1, 6,0, 1,1, 0,0, 0,0});
    vecs.push_back('{0,1, 1, 7,0, 0,1, 0,0, 0,0});
    vecs.push_back('{0,1, 1, 0,1, 0,0, 0,0, 0,0});
    vecs.push_back('{0,1,15, 7,2, 0,1, 0,1, 0,0});
    vecs.push_back('{0,1, 1, 0,3, 0,0, 1,1, 0,0});
    vecs.push_back('{0,0, 3, 0,3, 0,0, 1,1, 0,0});
    vecs.push_back('{0,1,15, 7,4, 0,1, 0,1, 0,0});
    vecs.push_back('{0,1, 1, 0,0, 0,0, 0,0, 1,1});
    vecs.push_back('{0,1, 1, 1,0, 0,0, 0,0, 0,1});
    vecs.push_back('{0,0, 1, 1,0, 0,0, 0,0, 0,1});
    vecs.push_back('{0,1,39, 0,0, 0,0, 0,0, 1,2});
    vecs.push_back('{0,1,39, 7,4, 0,1, 0,1, 0,2});
    vecs.push_back('{0,0, 1, 7,4, 0,1, 0,1, 0,2});
    vecs.push_back('{0,1, 1, 0,0, 0,0, 0,0, 1,3});
    vecs.push_back('{0,1,20, 4,2, 0,1, 0,1, 0,3});
    vecs.push_back('{1,1, 1, 0,0, 0,0, 0,0, 0,0});
    vecs.push_back('{0,1,40, 0,0, 0,0, 0,0, 1,1});
    vecs.push_back('{0,1,39, 7,4, 0,1, 0,1, 0,1});
    vecs.push_back('{1,1, 1, 0,0, 0,0, 0,0, 0,0});

    for (int i = 0; i < vecs.size(); i++) begin
      for (int k = 0; k < vecs[i].n; k++) step_s(vecs[i].r, vecs[i].c);
      chk($sformatf("v%0d hcount", i), int'(hc_s), vecs[i].h);
      chk($sformatf("v%0d vcount", i), int'(vc_s), vecs[i].v);
      chk($sformatf("v%0d hsync", i), int'(hs_s), int'(vecs[i].hs));
      chk($sformatf("v%0d hblnk", i), int'(hb_s), int'(vecs[i].hb));
      chk($sformatf("v%0d vsync", i), int'(vs_s), int'(vecs[i].vs));
      chk($sformatf("v%0d vblnk", i), int'(vb_s), int'(vecs[i].vb));
      chk($sformatf("v%0d tick", i), int'(tk_s), int'(vecs[i].tk));
      chk($sformatf("v%0d frame_cnt", i), int'(fc_s), vecs[i].cnt);
    end

    // ce toggling 1-0-1 from (0,0): first tick after 79 cycles, then period 80
    phase = 1'b1;
    n = 0; got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      step_s(1'b0, phase);
      phase = ~phase;
      n++;
      if (tk_s) got = 1'b1;
    end
    chk("toggle first tick seen", int'(got), 1);
    chk("toggle first tick cycle", n, 79);
    chk("toggle frame_cnt 1", int'(fc_s), 1);
    step_s(1'b0, phase); phase = ~phase;
    chk("toggle tick width", int'(tk_s), 0);
    n = 1; got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      step_s(1'b0, phase);
      phase = ~phase;
      n++;
      if (tk_s) got = 1'b1;
    end
    chk("toggle second tick seen", int'(got), 1);
    chk("toggle period", n, 80);
    chk("toggle frame_cnt 2", int'(fc_s), 2);
    step_s(1'b1, 1'b0);

    // Full-size: one line after reset
    step_f(1'b1, 1'b1);
    chk("full reset hcount", int'(hc_f), 0);
    chk("full reset hsync", int'(hs_f), 1);
    chk("full reset vsync", int'(vs_f), 1);
    chk("full reset tick", int'(tk_f), 0);
    hs_low = 0;
    for (int i = 1; i <= 1344; i++) begin
      step_f(1'b0, 1'b1);
      chk("line hcount", int'(hc_f), i % 1344);
      chk("line hblnk", int'(hb_f), ((i % 1344) >= 1024) ? 1 : 0);
      chk("line hsync", int'(hs_f), ((i % 1344) >= 1048 && (i % 1344) < 1184) ? 0 : 1);
      chk("line vcount", int'(vc_f), (i == 1344) ? 1 : 0);
      if (!hs_f) hs_low++;
    end
    chk("hsync low width", hs_low, 136);
    chk("line vblnk", int'(vb_f), 0);
    chk("line vsync", int'(vs_f), 1);

    // Reset mid-line at (500,1)
    for (int i = 0; i < 500; i++) step_f(1'b0, 1'b1);
    chk("pre-reset hcount", int'(hc_f), 500);
    chk("pre-reset vcount", int'(vc_f), 1);
    step_f(1'b1, 1'b1);
    chk("mid reset hcount", int'(hc_f), 0);
    chk("mid reset vcount", int'(vc_f), 0);
    chk("mid reset tick", int'(tk_f), 0);
    chk("mid reset frame_cnt", int'(fc_f), 0);
    step_f(1'b0, 1'b1);
    chk("restart hcount", int'(hc_f), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_timing.md
Name: vga_timing

Overview:
- Generates the raster timing that feeds the video pipeline: hcount/vcount, hsync/vsync and hblnk/vblnk for 1024x768 @ 60 Hz (65 MHz pixel clock).
- Downstream drawing stages consume these signals directly, e.g. the background/frame renderer.
- Also provides a one-cycle frame tick and a frame counter. Game logic uses these to pace snake movement.

Parameters:
- H_ACTIVE, 1024, visible pixels per line
- H_FP, 24, horizontal front porch (pixels)
- H_SYNC, 136, hsync width (pixels)
- H_BP, 160, horizontal back porch (pixels)
- V_ACTIVE, 768, visible lines per frame
- V_FP, 3, vertical front porch (lines)
- V_SYNC, 6, vsync width (lines)
- V_BP, 29, vertical back porch (lines)
- HSYNC_POL, 0, active level of hsync_out (0 = active-low)
- VSYNC_POL, 0, active level of vsync_out (0 = active-low)
- Derived: H_TOTAL = sum of H_* = 1344; V_TOTAL = sum of V_* = 806. Both must be ≤ 2048.

Ports:
- pclk  in  1  pixel clock
- rst  in  1  reset; synchronous, active-high
- ce  in  1  pixel enable; counters advance only when 1 (tie to 1 for full rate)
- hcount_out  out  11  horizontal position, 0..H_TOTAL-1
- hsync_out  out  1  horizontal sync, polarity per HSYNC_POL
- hblnk_out  out  1  horizontal blanking
- vcount_out  out  11  vertical line, 0..V_TOTAL-1
- vsync_out  out  1  vertical sync, polarity per VSYNC_POL
- vblnk_out  out  1  vertical blanking
- frame_tick  out  1  single-pclk pulse at frame wrap
- frame_cnt  out  16  frames completed since reset, modulo 2^16

Behaviour:
- Clocking and reset:
  - One clock: pclk. Reset is synchronous and active-high on rst.
  - All outputs are registered; no combinational paths from inputs to outputs.
- Reset values:
  - hcount_out = 0, vcount_out = 0.
  - hblnk_out = 0, vblnk_out = 0.
  - hsync_out = ~HSYNC_POL, vsync_out = ~VSYNC_POL (inactive level).
  - frame_tick = 0, frame_cnt = 0.
- Reset mid-frame returns to these values on the next pclk edge. rst has priority over ce.
- Horizontal counter, on each pclk with ce = 1:
  - hcount ← hcount + 1.
  - If hcount == H_TOTAL-1, hcount ← 0 instead (wrap).
- Vertical counter:
  - Advances only in the cycle where hcount wraps.
  - vcount ← vcount + 1; if vcount == V_TOTAL-1, vcount ← 0.
- Decode (registered, exactly aligned with the count values on the same cycle):
  - hblnk_out = 1 iff hcount_out ≥ H_ACTIVE.
  - hsync_out active iff H_ACTIVE+H_FP ≤ hcount_out < H_ACTIVE+H_FP+H_SYNC (1048..1183).
  - vblnk_out = 1 iff vcount_out ≥ V_ACTIVE.
  - vsync_out active iff V_ACTIVE+V_FP ≤ vcount_out < V_ACTIVE+V_FP+V_SYNC (771..776).
  - Implementation: decode from next-state counts so there is zero latency between counts and flags.
- Frame wrap (counters go from (H_TOTAL-1, V_TOTAL-1) to (0,0)):
  - frame_tick = 1 for exactly one pclk: the first cycle in which (0,0) is displayed.
  - frame_cnt increments in that same cycle and wraps 0xFFFF → 0x0000.
- frame_tick is not asserted on leaving reset, even though the counts are (0,0).
- ce = 0: all counters and flags hold their values; frame_tick = 0.
- Frame period at ce = 1: H_TOTAL × V_TOTAL = 1,083,264 pclk.

Test Plan:
- Reset, ce = 1, run one line → hcount steps 0..1343 then 0.
  - hblnk rises at hcount = 1024.
  - hsync low for hcount 1048..1183 (136 cycles), high elsewhere.
  - vcount 0→1 on the cycle hcount shows 0.
- Run a full frame → vblnk = 1 for vcount 768..805.
  - vsync low for vcount 771..776 (6 lines × 1344 cycles).
  - frame_tick pulses once, 1,083,264 cycles after reset release; frame_cnt = 1.
- Toggle ce 1-0-1 every cycle → counts advance every other pclk.
  - Frame period becomes 2,166,528 pclk; frame_tick width stays one pclk.
- Assert rst at hcount = 500, vcount = 300 for one cycle → next cycle shows all reset values.
  - No frame_tick; the count restarts at 0.
- Force-run 65,536 frames (or use a reduced-parameter instance, e.g. H_TOTAL = 8, V_TOTAL = 4) → frame_cnt wraps 0xFFFF → 0x0000 coincident with frame_tick.
- HSYNC_POL = 1, VSYNC_POL = 1 → syncs idle low and pulse high over the same count windows.
